axi_mem_responder: RTL

- AXI4 memory subordinate that answers traffic-generator bursts on the external-memory interface.
- Backed by on-chip RAM; stands in for the EMIF channel in builds without DDR4 and in block-level TG regressions.
- Independent write and read engines:
  - write engine: AW/W/B
  - read engine: AR/R

---
 rtl/axi_mem_rsp_pkg.sv | 17 +
 rtl/axi_mem_rsp_ram.sv | 35 +++
 rtl/axi_mem_responder.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/axi_mem_rsp_pkg.sv
// rtl/axi_mem_rsp_pkg.sv - shared FSM state encodings and AXI response/burst constants
package axi_mem_rsp_pkg;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;

    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_ADDR = 2'd1;
    localparam logic [1:0] R_DATA = 2'd2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] BURST_INCR = 2'b01;

endpackage

// File: rtl/axi_mem_rsp_ram.sv
// rtl/axi_mem_rsp_ram.sv - simple dual-port RAM, byte-enable write, registered 1-cycle read
module axi_mem_rsp_ram #(
    parameter int unsigned DATA_W = 512,
    parameter int unsigned MEM_AW = 10
) (
    input  logic                clk,
    input  logic                we_i,
    input  logic [MEM_AW-1:0]   waddr_i,
    input  logic [DATA_W-1:0]   wdata_i,
    input  logic [DATA_W/8-1:0] wstrb_i,
    input  logic                re_i,
    input  logic [MEM_AW-1:0]   raddr_i,
    output logic [DATA_W-1:0]   rdata_o
);

    logic [DATA_W-1:0] mem_q [2**MEM_AW];
    logic [DATA_W-1:0] rdata_q;

    // Read and write share one edge, so a same-word collision reads the old contents.
    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int b = 0; b < DATA_W/8; b++) begin
                if (wstrb_i[b]) begin
                    mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/axi_mem_responder.sv
// rtl/axi_mem_responder.sv - AXI4 RAM-backed memory subordinate with independent write/read engines
// Optional macro AXI_MEM_RESP_BURST_CHECK_EN: non-INCR bursts answer SLVERR.
module axi_mem_responder
    import axi_mem_rsp_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 512,
    parameter int unsigned ID_W   = 8,
    parameter int unsigned MEM_AW = 10,
    parameter int unsigned LEN_W  = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                awvalid_i,
    output logic                awready_o,
    input  logic [ID_W-1:0]     awid_i,
    input  logic [ADDR_W-1:0]   awaddr_i,
    input  logic [LEN_W-1:0]    awlen_i,
    input  logic [1:0]          awburst_i,
    input  logic                wvalid_i,
    output logic                wready_o,
    input  logic [DATA_W-1:0]   wdata_i,
    input  logic [DATA_W/8-1:0] wstrb_i,
    input  logic                wlast_i,
    output logic                bvalid_o,
    input  logic                bready_i,
    output logic [ID_W-1:0]     bid_o,
    output logic [1:0]          bresp_o,
    input  logic                arvalid_i,
    output logic                arready_o,
    input  logic [ID_W-1:0]     arid_i,
    input  logic [ADDR_W-1:0]   araddr_i,
    input  logic [LEN_W-1:0]    arlen_i,
    input  logic [1:0]          arburst_i,
    output logic                rvalid_o,
    input  logic                rready_i,
    output logic [ID_W-1:0]     rid_o,
    output logic [DATA_W-1:0]   rdata_o,
    output logic [1:0]          rresp_o,
    output logic                rlast_o
);

    localparam int unsigned OFF = $clog2(DATA_W/8);

    logic              aw_bad, ar_bad;
    logic              unused_ok;

`ifdef AXI_MEM_RESP_BURST_CHECK_EN
    assign aw_bad = (awburst_i != BURST_INCR);
    assign ar_bad = (arburst_i != BURST_INCR);
`else
    assign aw_bad = 1'b0;
    assign ar_bad = 1'b0;
`endif

    // Upper address bits alias and byte-offset bits are dropped by design.
    assign unused_ok = ^{awaddr_i, araddr_i, awburst_i, arburst_i};

    logic [1:0]        w_state_q, w_state_d;
    logic [ID_W-1:0]   w_id_q, w_id_d;
    logic [MEM_AW-1:0] w_idx_q, w_idx_d;
    logic [LEN_W-1:0]  w_len_q, w_len_d;
    logic [LEN_W-1:0]  w_cnt_q, w_cnt_d;
    logic              w_err_q, w_err_d;
    logic              w_bad_q, w_bad_d;
    logic              w_at_len;
    logic              ram_we;

    assign w_at_len = (w_cnt_q == w_len_q);

    always_comb begin
        w_state_d = w_state_q;
        w_id_d    = w_id_q;
        w_idx_d   = w_idx_q;
        w_len_d   = w_len_q;
        w_cnt_d   = w_cnt_q;
        w_err_d   = w_err_q;
        w_bad_d   = w_bad_q;
        ram_we    = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (awvalid_i) begin
                    w_id_d    = awid_i;
                    w_idx_d   = awaddr_i[OFF +: MEM_AW];
                    w_len_d   = awlen_i;
                    w_cnt_d   = '0;
                    w_err_d   = 1'b0;
                    w_bad_d   = aw_bad;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (wvalid_i) begin
                    ram_we  = !w_bad_q;
                    w_idx_d = w_idx_q + MEM_AW'(1);
                    w_cnt_d = w_cnt_q + LEN_W'(1);
                    // Burst closes on whichever of wlast / length comes first; disagreement is an error.
                    if (wlast_i || w_at_len) begin
                        w_err_d   = (wlast_i != w_at_len);
                        w_state_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (bready_i) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_state_q <= W_IDLE;
            w_id_q    <= '0;
            w_idx_q   <= '0;
            w_len_q   <= '0;
            w_cnt_q   <= '0;
            w_err_q   <= 1'b0;
            w_bad_q   <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            w_id_q    <= w_id_d;
            w_idx_q   <= w_idx_d;
            w_len_q   <= w_len_d;
            w_cnt_q   <= w_cnt_d;
            w_err_q   <= w_err_d;
            w_bad_q   <= w_bad_d;
        end
    end

    assign awready_o = rst_n && (w_state_q == W_IDLE);
    assign wready_o  = rst_n && (w_state_q == W_DATA);
    assign bvalid_o  = rst_n && (w_state_q == W_RESP);
    assign bid_o     = bvalid_o ? w_id_q : '0;
    assign bresp_o   = (bvalid_o && (w_err_q || w_bad_q)) ? RESP_SLVERR : RESP_OKAY;

    logic [1:0]        r_state_q, r_state_d;
    logic [ID_W-1:0]   r_id_q, r_id_d;
    logic [MEM_AW-1:0] r_idx_q, r_idx_d;
    logic [LEN_W-1:0]  r_len_q, r_len_d;
    logic [LEN_W-1:0]  r_cnt_q, r_cnt_d;
    logic              r_bad_q, r_bad_d;
    logic              r_at_len;
    logic              ram_re;
    logic [DATA_W-1:0] ram_rdata;

    assign r_at_len = (r_cnt_q == r_len_q);
    assign ram_re   = (r_state_q == R_ADDR);

    always_comb begin
        r_state_d = r_state_q;
        r_id_d    = r_id_q;
        r_idx_d   = r_idx_q;
        r_len_d   = r_len_q;
        r_cnt_d   = r_cnt_q;
        r_bad_d   = r_bad_q;
        case (r_state_q)
            R_IDLE: begin
                if (arvalid_i) begin
                    r_id_d    = arid_i;
                    r_idx_d   = araddr_i[OFF +: MEM_AW];
                    r_len_d   = arlen_i;
                    r_cnt_d   = '0;
                    r_bad_d   = ar_bad;
                    r_state_d = R_ADDR;
                end
            end
            R_ADDR: r_state_d = R_DATA;
            R_DATA: begin
                if (rready_i) begin
                    if (r_at_len) begin
                        r_state_d = R_IDLE;
                    end else begin
                        r_idx_d   = r_idx_q + MEM_AW'(1);
                        r_cnt_d   = r_cnt_q + LEN_W'(1);
                        r_state_d = R_ADDR;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state_q <= R_IDLE;
            r_id_q    <= '0;
            r_idx_q   <= '0;
            r_len_q   <= '0;
            r_cnt_q   <= '0;
            r_bad_q   <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            r_id_q    <= r_id_d;
            r_idx_q   <= r_idx_d;
            r_len_q   <= r_len_d;
            r_cnt_q   <= r_cnt_d;
            r_bad_q   <= r_bad_d;
        end
    end

    assign arready_o = rst_n && (r_state_q == R_IDLE);
    assign rvalid_o  = rst_n && (r_state_q == R_DATA);
    assign rid_o     = rvalid_o ? r_id_q : '0;
    assign rdata_o   = (rvalid_o && !r_bad_q) ? ram_rdata : '0;
    assign rresp_o   = (rvalid_o && r_bad_q) ? RESP_SLVERR : RESP_OKAY;
    assign rlast_o   = rvalid_o && r_at_len;

    axi_mem_rsp_ram #(
        .DATA_W (DATA_W),
        .MEM_AW (MEM_AW)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (w_idx_q),
        .wdata_i (wdata_i),
        .wstrb_i (wstrb_i),
        .re_i    (ram_re),
        .raddr_i (r_idx_q),
        .rdata_o (ram_rdata)
    );

endmodule
